// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Parametrised raster timing generator. A clock divider produces a one-cycle
// pixel strobe every CLK_DIV clk cycles. The x/y position, data-enable and
// both sync outputs are registers that advance together on the strobe.
// Because they share one load enable, they are always mutually aligned.
//
// Optional feature macro: VTG_FRAME_CNT_EN
//   When defined, the frame_cnt port is added. It is a 16-bit frame counter
//   that advances on the (H_TOTAL-1, V_TOTAL-1) -> (0,0) wrap.
//
// Ports
//   clk         in   system clock (the only clock)
//   rst_n       in   asynchronous active-low reset
//   pix_stb     out  high in the last clk cycle of each pixel period
//   x, y        out  current raster position (CW bits each)
//   de          out  high inside the active area
//   h_sync      out  H_POL inside the horizontal sync window, else ~H_POL
//   v_sync      out  V_POL inside the vertical sync window, else ~V_POL
//   line_start  out  pix_stb while x == 0
//   frame_cnt   out  16-bit frame counter (VTG_FRAME_CNT_EN only)
//   frame_start out  pix_stb while x == 0 and y == 0
// ---------------------------------------------------------------------------
module video_timing_gen #(
  parameter int CW       = 12,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CLK_DIV  = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          pix_stb,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          de,
  output logic          h_sync,
  output logic          v_sync,
  output logic          line_start,
`ifdef VTG_FRAME_CNT_EN
  output logic [15:0]   frame_cnt,
`endif
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The divider needs at least one bit, even when CLK_DIV is 1.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] Y_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = 1'(H_POL);
  localparam logic VS_ON = 1'(V_POL);

  logic [DW-1:0] div_cnt;
  logic [CW-1:0] x_nxt;
  logic [CW-1:0] y_nxt;
  logic          de_nxt;
  logic          hs_act_nxt;
  logic          vs_act_nxt;

  // Pixel-clock divider. div_cnt restarts at 0 on reset, so the first pixel
  // after reset release is always a full CLK_DIV cycles long.
  assign pix_stb = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (pix_stb) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Next raster position. y only moves on the x wrap, so vertical transitions
  // land on the same edge as the x -> 0 wrap.
  always_comb begin
    x_nxt = x + CW'(1);
    y_nxt = y;
    if (x == X_LAST) begin
      x_nxt = '0;
      y_nxt = (y == Y_LAST) ? '0 : (y + CW'(1));
    end
  end

  // The decode runs on the next position, so the registered outputs line up
  // with the registered x/y. Sync windows include the start and exclude the end.
  always_comb begin
    de_nxt     = (x_nxt < X_ACT) && (y_nxt < Y_ACT);
    hs_act_nxt = (x_nxt >= HS_START) && (x_nxt < HS_END);
    vs_act_nxt = (y_nxt >= VS_START) && (y_nxt < VS_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x      <= '0;
      y      <= '0;
      de     <= 1'b1;
      h_sync <= ~HS_ON;
      v_sync <= ~VS_ON;
    end else if (pix_stb) begin
      x      <= x_nxt;
      y      <= y_nxt;
      de     <= de_nxt;
      h_sync <= hs_act_nxt ? HS_ON : ~HS_ON;
      v_sync <= vs_act_nxt ? VS_ON : ~VS_ON;
    end
  end

  assign line_start  = pix_stb && (x == '0);
  assign frame_start = line_start && (y == '0);

`ifdef VTG_FRAME_CNT_EN
  // The counter advances on the edge that takes the raster from the last
  // pixel of a frame back to (0,0). It wraps naturally modulo 2^16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (pix_stb && (x == X_LAST) && (y == Y_LAST)) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//
// Bench for video_timing_gen. It runs three instances in the tiny mode
// (H 4/1/2/1, V 3/1/1/1). The instances share one clock and one reset:
//   d0: CLK_DIV=2, active-low syncs
//   d1: CLK_DIV=3, active-high syncs
//   d2: CLK_DIV=1, active-low syncs
// The reference model derives every output from k alone. k is the number of
// clk edges since reset release. The model uses plain arithmetic:
//   pixel index = k / CLK_DIV
//   x = pixel % H_TOTAL
//   y = (pixel / H_TOTAL) % V_TOTAL
// With VTG_FRAME_CNT_EN defined, frame_cnt is also checked, including a
// preload to 0xFFFF on d2.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int TCW = 4;

  typedef struct packed {
    logic        stb;
    logic [31:0] x;
    logic [31:0] y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int fc_base = 0;

  logic           stb [3];
  logic [TCW-1:0] px  [3];
  logic [TCW-1:0] py  [3];
  logic           de  [3];
  logic           hs  [3];
  logic           vs  [3];
  logic           ls  [3];
  logic           fs  [3];
`ifdef VTG_FRAME_CNT_EN
  logic [15:0]    fc  [3];
`endif

  video_timing_gen #(.CW(TCW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .H_POL(0), .V_POL(0),
    .CLK_DIV(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .pix_stb(stb[0]), .x(px[0]), .y(py[0]),
    .de(de[0]), .h_sync(hs[0]), .v_sync(vs[0]), .line_start(ls[0]),
`ifdef VTG_FRAME_CNT_EN
    .frame_cnt(fc[0]),
`endif
    .frame_start(fs[0]));

  video_timing_gen #(.CW(TCW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .H_POL(1), .V_POL(1),
    .CLK_DIV(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_stb(stb[1]), .x(px[1]), .y(py[1]),
    .de(de[1]), .h_sync(hs[1]), .v_sync(vs[1]), .line_start(ls[1]),
`ifdef VTG_FRAME_CNT_EN
    .frame_cnt(fc[1]),
`endif
    .frame_start(fs[1]));

  video_timing_gen #(.CW(TCW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .H_POL(0), .V_POL(0),
    .CLK_DIV(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .pix_stb(stb[2]), .x(px[2]), .y(py[2]),
    .de(de[2]), .h_sync(hs[2]), .v_sync(vs[2]), .line_start(ls[2]),
`ifdef VTG_FRAME_CNT_EN
    .frame_cnt(fc[2]),
`endif
    .frame_start(fs[2]));

  // reference model
  function automatic int div_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 3 : 1);
  endfunction

  function automatic bit pol_of(input int i);
    return (i == 1);
  endfunction

  function automatic exp_t model(input int kk, input int d, input bit pol);
    exp_t e;
    int p;
    p    = kk / d;
    e.stb = ((kk % d) == d - 1);
    e.x  = 32'(p % HT);
    e.y  = 32'((p / HT) % VT);
    e.de = (p % HT < HA) && ((p / HT) % VT < VA);
    e.hs = ((p % HT >= HA + HF) && (p % HT < HA + HF + HS)) ? pol : ~pol;
    e.vs = (((p / HT) % VT >= VA + VF) && ((p / HT) % VT < VA + VF + VS)) ? pol : ~pol;
    e.ls = e.stb && (p % HT == 0);
    e.fs = e.ls && ((p / HT) % VT == 0);
    return e;
  endfunction

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  task automatic check_all();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e = model(k, div_of(i), pol_of(i));
      check($sformatf("d%0d.pix_stb", i), 32'(stb[i]), 32'(e.stb));
      check($sformatf("d%0d.x", i), 32'(px[i]), e.x);
      check($sformatf("d%0d.y", i), 32'(py[i]), e.y);
      check($sformatf("d%0d.de", i), 32'(de[i]), 32'(e.de));
      check($sformatf("d%0d.h_sync", i), 32'(hs[i]), 32'(e.hs));
      check($sformatf("d%0d.v_sync", i), 32'(vs[i]), 32'(e.vs));
      check($sformatf("d%0d.line_start", i), 32'(ls[i]), 32'(e.ls));
      check($sformatf("d%0d.frame_start", i), 32'(fs[i]), 32'(e.fs));
`ifdef VTG_FRAME_CNT_EN
      if (i == 2)
        check("d2.frame_cnt", 32'(fc[i]), 32'((fc_base + k / (HT * VT)) % 65536));
      else
        check($sformatf("d%0d.frame_cnt", i), 32'(fc[i]),
              32'((k / (HT * VT * div_of(i))) % 65536));
`endif
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    if (rst_n) k++;
    @(negedge clk);
    check_all();
  endtask

  // Assert reset asynchronously between a posedge and the next negedge.
  task automatic async_reset(input int dly, input int hold);
    @(posedge clk);
    if (rst_n) k++;
    #(dly);
    rst_n = 1'b0;
    k = 0;
    fc_base = 0;
    #1;
    check_all();
    @(negedge clk);
    check_all();
    repeat (hold) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
    #1;
    check_all();
  endtask

  initial begin
    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    #1;
    check_all();

    // Directed: run d0 to x=6, y=2, then reset mid-line.
    while (k < 45) step();
    check("pre_rst.d0.x", 32'(px[0]), 32'd6);
    check("pre_rst.d0.y", 32'(py[0]), 32'd2);
    async_reset(2, 2);
    check("post_rst.d0.x", 32'(px[0]), 32'd0);
    check("post_rst.d1.h_sync", 32'(hs[1]), 32'd0);

    // Three frames of the slowest instance cover full frames on all three.
    repeat (3 * HT * VT * 3 + 5) step();

`ifdef VTG_FRAME_CNT_EN
    // Preload d2's counter to 0xFFFF; the next wrap must give 0x0000.
    force dut_c.frame_cnt = 16'hFFFF;
    #1;
    release dut_c.frame_cnt;
    fc_base = 65535 - (k / (HT * VT));
    repeat (3 * HT * VT) step();
`endif

    // randomized segments with random asynchronous resets
    for (int s = 0; s < 20; s++) begin
      repeat ($urandom_range(5, 300)) step();
      async_reset(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
    end
    repeat (200) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator producing pixel strobe, active-pixel coordinates, data-enable and sync outputs for any CEA/VESA-style mode. It is the successor to the fixed 640x480 sync counter: porches, sync widths, sync polarities, pixel-clock divide ratio and counter width are all parameters. Its decode is exact to the pixel. It feeds the pixel-generation pipeline and the TMDS/VGA output stage from the single system clock.

## Interface
- CW, 12, width of x/y counters; must hold H_TOTAL-1 and V_TOTAL-1
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync asserted level (0 = active-low, 1 = active-high)
- V_POL, 0, vsync asserted level
- CLK_DIV, 10, clk cycles per pixel, ≥1
- clk  in  1  system clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- pix_stb  out  1  high in the last clk cycle of each pixel period
- x  out  CW  current horizontal position, 0..H_TOTAL-1
- y  out  CW  current vertical position, 0..V_TOTAL-1
- de  out  1  high when x<H_ACTIVE and y<V_ACTIVE
- h_sync  out  1  H_POL while x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~H_POL
- v_sync  out  1  V_POL while y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], else ~V_POL
- line_start  out  1  pix_stb && x==0
- frame_start  out  1  pix_stb && x==0 && y==0
- frame_cnt  out  16  frame counter (only with VTG_FRAME_CNT_EN)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Each sync window is exactly H_SYNC/V_SYNC units wide, inclusive start, exclusive end.
- Divider div_cnt counts 0..CLK_DIV-1 and wraps. pix_stb = (div_cnt == CLK_DIV-1). For CLK_DIV=1, pix_stb is constantly high after reset.
- On a clk edge with pix_stb high:
  - x at H_TOTAL-1: x wraps to 0. y increments, or wraps to 0 at V_TOTAL-1.
  - otherwise x increments and y holds.
- x, y, de, h_sync and v_sync are registers loaded on the same edge, so they are always mutually aligned. de/h_sync/v_sync are decoded from the next position; there is no combinational path from the counters to these outputs.
- line_start and frame_start are combinational from pix_stb and the registered x/y.
- Reset (rst_n low, asynchronous):
  - div_cnt=0, x=0, y=0
  - de=1 (position 0,0 is active)
  - h_sync=~H_POL, v_sync=~V_POL
  - frame_cnt=0
- Reset deasserted mid-frame: output restarts at (0,0) with a full first pixel of CLK_DIV clks. There is no partial pixel.

## Timing
- Pixel period is CLK_DIV clk cycles. Line is H_TOTAL*CLK_DIV clks. Frame is H_TOTAL*V_TOTAL*CLK_DIV clks.
- Latency: outputs change one clk edge after the pix_stb cycle, i.e. every CLK_DIV clks.
- First pix_stb occurs in clk cycle CLK_DIV-1 after reset release (cycle 0 being the first edge with rst_n high).
- Vertical transitions (y change, v_sync edges) coincide exactly with the x 0 wrap edge.
- Wrap of y and x on the same edge returns to (0,0). frame_start is high in the pix_stb cycle of the first pixel of every frame, including the first frame after reset.

## Configuration
- VTG_FRAME_CNT_EN defined: frame_cnt port exists. It increments by 1, modulo 2^16, on the edge where (x,y) wraps from (H_TOTAL-1,V_TOTAL-1) to (0,0). 0xFFFF wraps to 0x0000.
- Undefined: no frame_cnt port and no counter logic. All other behaviour is identical.

## Test plan
- Tiny mode H 4/1/2/1, V 3/1/1/1, CLK_DIV=2, polarities 0 -> frame = 96 clks; x sequence 0..7, y sequence 0..5; de high for exactly 12 pixels per frame.
- Same mode -> h_sync low exactly at x=5,6 (4 clks per line); v_sync low exactly for y=4 (16 clks); both edges coincide with x/y updates.
- H_POL=1, V_POL=1 -> sync windows inverted: high at x=5,6 and y=4; reset values h_sync=0, v_sync=0.
- CLK_DIV=1 -> pix_stb constant 1; x advances every clk; line_start every 8 clks; frame_start every 48 clks.
- Assert rst_n low asynchronously mid-line at x=6, y=2 -> x=0, y=0, de=1, syncs inactive immediately; after release, first pix_stb in cycle CLK_DIV-1.
- With VTG_FRAME_CNT_EN: run 3 frames -> frame_cnt 0,1,2,3 at each (0,0) wrap; force-preload 0xFFFF -> next wrap gives 0x0000.
